// File: rtl/multi_button_toggle.sv
// multi_button_toggle
//   N-channel pushbutton front end. Each channel has a 2-FF synchroniser,
//   a registered rising-edge detect, a lockout FSM timed by one shared tick
//   prescaler, and a toggle register.
//
// Ports
//   clk_ms      in   master clock, all logic on its rising edge
//   reset_n     in   synchronous active-low reset
//   btn         in   raw asynchronous button levels, 1 = pressed
//   clear       in   per-channel synchronous clear of the toggle level
//   pulse       out  one-cycle strobe per accepted press
//   state       out  toggle level, inverts on each accepted press
//   busy        out  1 while the channel is in LOCK or WAIT_REL
//   long_press  out  one-cycle strobe on a long hold (optional)
//   tick        out  shared prescaler strobe, one cycle every TICK_PERIOD
//
// Optional feature macro: MULTI_BUTTON_LONG_PRESS_EN
//   Defined   : long_press fires once per press when the hold reaches
//               LONG_TICKS ticks.
//   Undefined : long_press is tied to 0.
//
// Channel FSM
//   state       | meaning
//   ST_IDLE     | waiting for a rising edge on the synchronised input
//   ST_LOCK     | press accepted, input ignored until LOCKOUT_TICKS ticks
//   ST_WAIT_REL | lockout over, waiting for the button to be released

module multi_button_toggle #(
    parameter int CHANNELS      = 4,
    parameter int TICK_PERIOD   = 25000,
    parameter int TICK_W        = 16,
    parameter int LOCKOUT_TICKS = 100,
    parameter int LONG_TICKS    = 1000
) (
    input  logic                clk_ms,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] btn,
    input  logic [CHANNELS-1:0] clear,
    output logic [CHANNELS-1:0] pulse,
    output logic [CHANNELS-1:0] state,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] long_press,
    output logic                tick
);

    if (CHANNELS < 1 || CHANNELS > 16 || TICK_PERIOD < 1 ||
        (TICK_PERIOD - 1) >= (1 << TICK_W) ||
        LOCKOUT_TICKS < 1 || LOCKOUT_TICKS > 255 ||
        LONG_TICKS <= LOCKOUT_TICKS || LONG_TICKS > 65535) begin : g_bad_params
        $error("multi_button_toggle: parameter out of range");
    end

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_PERIOD - 1);
    localparam logic [15:0]       LOCK_CNT  = 16'(LOCKOUT_TICKS);
    localparam logic [15:0]       CNT_SAT   = 16'hFFFF;
`ifdef MULTI_BUTTON_LONG_PRESS_EN
    localparam logic [15:0]       LONG_CNT  = 16'(LONG_TICKS);
`endif

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOCK     = 2'd1,
        ST_WAIT_REL = 2'd2
    } ch_state_e;

    // Shared prescaler
    logic [TICK_W-1:0] presc_q, presc_d;
    logic              tick_int;

    assign tick_int = (presc_q == TICK_LAST);
    assign presc_d  = tick_int ? '0 : presc_q + TICK_W'(1);
    assign tick     = tick_int;

    always_ff @(posedge clk_ms) begin
        if (!reset_n) presc_q <= '0;
        else          presc_q <= presc_d;
    end

    // Synchroniser and edge detect. The fill counter keeps the edge detect
    // quiet until s2_prev_q holds a real post-reset sample, so a button
    // already held through reset is not mistaken for a press.
    logic [CHANNELS-1:0] s1_q, s2_q, s2_prev_q, edge_q;
    logic [1:0]          fill_q;
    logic                sync_ok;

    assign sync_ok = (fill_q == 2'd3);

    always_ff @(posedge clk_ms) begin
        if (!reset_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s2_prev_q <= '0;
            edge_q    <= '0;
            fill_q    <= 2'd0;
        end else begin
            s1_q      <= btn;
            s2_q      <= s1_q;
            s2_prev_q <= s2_q;
            edge_q    <= sync_ok ? (s2_q & ~s2_prev_q) : '0;
            if (!sync_ok) fill_q <= fill_q + 2'd1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        ch_state_e   fsm_q;
        logic [15:0] cnt_q;
        logic        pulse_q, state_q, busy_q;
        logic        accept;

        assign accept = (fsm_q == ST_IDLE) && edge_q[g];

`ifdef MULTI_BUTTON_LONG_PRESS_EN
        logic long_q, long_done_q;
        assign long_press[g] = long_q;
`else
        assign long_press[g] = 1'b0;
`endif

        always_ff @(posedge clk_ms) begin
            if (!reset_n) begin
                fsm_q   <= ST_IDLE;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
                state_q <= 1'b0;
                busy_q  <= 1'b0;
`ifdef MULTI_BUTTON_LONG_PRESS_EN
                long_q      <= 1'b0;
                long_done_q <= 1'b0;
`endif
            end else begin
                pulse_q <= accept;
                // clear has priority over a same-cycle toggle
                if (clear[g])    state_q <= 1'b0;
                else if (accept) state_q <= ~state_q;
`ifdef MULTI_BUTTON_LONG_PRESS_EN
                long_q <= 1'b0;
`endif
                case (fsm_q)
                    ST_IDLE: begin
                        if (edge_q[g]) begin
                            cnt_q  <= '0;
                            fsm_q  <= ST_LOCK;
                            busy_q <= 1'b1;
`ifdef MULTI_BUTTON_LONG_PRESS_EN
                            long_done_q <= 1'b0;
`endif
                        end
                    end
                    ST_LOCK: begin
                        // exit test uses the pre-increment count
                        if (tick_int) cnt_q <= cnt_q + 16'd1;
                        if (cnt_q == LOCK_CNT) fsm_q <= ST_WAIT_REL;
                    end
                    ST_WAIT_REL: begin
                        if (tick_int && cnt_q != CNT_SAT) cnt_q <= cnt_q + 16'd1;
                        if (!s2_q[g]) begin
                            fsm_q  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
`ifdef MULTI_BUTTON_LONG_PRESS_EN
                        // count sits at LONG_CNT for a whole tick period;
                        // the done flag limits the strobe to one cycle
                        else if (cnt_q == LONG_CNT && !long_done_q) begin
                            long_q      <= 1'b1;
                            long_done_q <= 1'b1;
                        end
`endif
                    end
                    default: begin
                        fsm_q  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end

        assign pulse[g] = pulse_q;
        assign state[g] = state_q;
        assign busy[g]  = busy_q;
    end

endmodule

// File: doc/multi_button_toggle.md
Name: multi_button_toggle

Overview:
- N-channel pushbutton front end: synchroniser, edge detect, lockout (monostable) timer and toggle register per channel.
- Timing comes from one shared tick prescaler, so there is one divider rather than one per button.
- Sits between raw board buttons and the chronometer control logic (start/stop, lap, reset).
- Gives each channel a one-cycle press pulse plus a toggle level, and replaces per-button debounce/toggle instances.

Parameters:
- CHANNELS, 4, number of independent button channels (1..16).
- TICK_PERIOD, 25000, clk_ms cycles per tick strobe (25 MHz -> 1 kHz).
- TICK_W, 16, prescaler counter width; must hold TICK_PERIOD-1.
- LOCKOUT_TICKS, 100, ticks after an accepted press during which input is ignored (1..255).
- LONG_TICKS, 1000, held-press threshold in ticks; used only with the optional feature (LOCKOUT_TICKS < LONG_TICKS < 65536).

Ports:
- clk_ms, in, 1, master clock; all logic on its rising edge.
- reset_n, in, 1, synchronous active-low reset.
- btn, in, CHANNELS, raw asynchronous button levels; 1 = pressed.
- clear, in, CHANNELS, synchronous per-channel clear of the toggle state.
- pulse, out, CHANNELS, one-cycle strobe per accepted press.
- state, out, CHANNELS, toggle level; inverts on each accepted press.
- busy, out, CHANNELS, 1 while the channel is not IDLE.
- long_press, out, CHANNELS, one-cycle strobe on a long hold (optional feature).
- tick, out, 1, shared prescaler strobe; one clk_ms cycle every TICK_PERIOD cycles.

Behaviour:
- Reset (reset_n sampled 0 at a clk_ms edge):
  - all outputs 0;
  - synchronisers 0, prescaler 0, all channels IDLE, per-channel tick counters 0.
  - Reset wins over every other event, including mid-lockout.
- Prescaler:
  - counts 0..TICK_PERIOD-1 and wraps.
  - tick = 1 in the cycle the count equals TICK_PERIOD-1.
  - Runs regardless of channel states.
- Input path: 2-FF synchroniser per channel, then a registered rising-edge detect (s2 & ~s2_d).
  - Latency: btn high, sampled at edge k, gives pulse = 1 after edge k+3.
- Per-channel FSM:
  - IDLE:
    - rising edge -> pulse = 1 for one cycle, state inverts, counter cleared to 0, go LOCK.
    - A level already high when IDLE is entered is not a press.
  - LOCK:
    - counter increments on each tick.
    - When the counter reaches LOCKOUT_TICKS, go WAIT_REL.
    - Edges and bounces are ignored.
    - Lockout duration is therefore between (LOCKOUT_TICKS-1)*TICK_PERIOD and LOCKOUT_TICKS*TICK_PERIOD cycles.
  - WAIT_REL:
    - s2 = 0 -> IDLE.
    - s2 = 1 -> stay; there is no auto-repeat.
    - The counter keeps incrementing and saturates at 65535.
- busy = 1 in LOCK and WAIT_REL.
- clear:
  - clear[i] = 1 forces state[i] to 0 next cycle.
  - If clear and an accepted press occur in the same cycle, clear wins for state; pulse is still emitted.
  - clear does not affect the FSM.
- Channels are fully independent: simultaneous presses on several channels each produce their own pulse in the same cycle.
- Tick and FSM transition in the same cycle: the increment and the comparison use the pre-increment value, so LOCK exits on the cycle after the counter equals LOCKOUT_TICKS.

Optional Feature:
- Macro: MULTI_BUTTON_LONG_PRESS_EN.
- Defined:
  - in WAIT_REL, when the counter first equals LONG_TICKS with s2 still 1, long_press = 1 for one cycle, once per press.
  - Release before LONG_TICKS produces no long_press.
- Undefined: long_press tied to 0; LONG_TICKS unused; the counter may be sized to LOCKOUT_TICKS only.

Test Plan:
1. CHANNELS=2, TICK_PERIOD=4, LOCKOUT_TICKS=3; reset_n=0 for 3 cycles with btn=2'b11 -> all outputs 0; after release, no pulse while btn stays high (level, not edge).
2. btn[0] 0->1 clean -> pulse[0]=1 exactly 3 cycles later for 1 cycle, state[0]=1, busy[0]=1; release after 20 cycles -> busy[0]=0.
3. btn[0] press then 5 bounces (toggling every 1 cycle) within the first 8 cycles -> exactly one pulse and state[0]=1; a second clean press after release -> state[0]=0.
4. btn=2'b11 rising in the same cycle -> pulse=2'b11 in the same cycle; then clear=2'b01 for one cycle -> state=2'b10.
5. Assert reset_n=0 while channel 0 is in LOCK -> next cycle busy=0, state=0, FSM IDLE; a fresh press is accepted normally.
6. With MULTI_BUTTON_LONG_PRESS_EN and LONG_TICKS=10, hold btn[0] for 60 cycles -> exactly one long_press[0] pulse, about 40 cycles after acceptance; without the macro, long_press stays 0.
